regfile_sb: RTL and testbench

- Parametrised successor to the baseline 2-read/1-write register file.
- Adds the following:
  - a per-register pending scoreboard for hazard detection;
  - a sequential clear engine that zeroes the file without a reset;
  - optional write-to-read bypass.
- Sits between decode (issue/read) and writeback in the CPU datapath.
- Register 0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with a per-register pending
// scoreboard, a sequential clear engine and optional write-to-read bypass.
// Register 0 is hardwired to zero.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward writeback data
// (and a cleared pending flag) to a read port in the same cycle.
module regfile_sb #(
   parameter int dtype    = 16,
   parameter int nregs    = 8,
   parameter int addr_len = $clog2(nregs)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [addr_len-1:0] rX_address,
   output logic [dtype-1:0]    rX,
   output logic                rX_pending,
   input  logic [addr_len-1:0] rY_address,
   output logic [dtype-1:0]    rY,
   output logic                rY_pending,
   input  logic                we,
   input  logic [addr_len-1:0] rZ_address,
   input  logic [dtype-1:0]    rZ,
   input  logic                issue_valid,
   input  logic [addr_len-1:0] issue_address,
   input  logic                clear_req,
   output logic                clear_busy,
   output logic                clear_done
);

   localparam logic [0:0]          S_IDLE   = 1'b0;
   localparam logic [0:0]          S_CLEAR  = 1'b1;
   localparam logic [addr_len-1:0] LAST_IDX = addr_len'(nregs - 1);

   logic [dtype-1:0]    regs [nregs];
   logic [nregs-1:0]    pending;
   logic [0:0]          state;
   logic [addr_len-1:0] ptr;
   logic                byp_x;
   logic                byp_y;

   // Clear-engine FSM, sweep pointer and completion pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         clear_done <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         clear_done <= 1'b0;
         if (state == S_IDLE) begin
            if (clear_req) begin
               state <= S_CLEAR;
               ptr   <= addr_len'(1);
            end
         end else if (ptr == LAST_IDX) begin
            state      <= S_IDLE;
            clear_done <= 1'b1;
         end else begin
            ptr <= ptr + addr_len'(1);
         end
      end
   end

   // Register storage and scoreboard: writeback/issue in IDLE, sweep in CLEAR.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the array is reset explicitly because the file must read
         // zero immediately on reset; this keeps it in flops, not SRAM.
         for (int i = 0; i < nregs; i++) regs[i] <= '0;
         pending <= '0;
      end else if (state == S_IDLE) begin
         if (we && rZ_address != '0) begin
            regs[rZ_address]    <= rZ;
            pending[rZ_address] <= 1'b0;
         end
         // Issue is evaluated last so a same-cycle producer leaves pending set.
         if (issue_valid && issue_address != '0) pending[issue_address] <= 1'b1;
      end else begin
         regs[ptr]    <= '0;
         pending[ptr] <= 1'b0;
      end
   end

   assign clear_busy = (state == S_CLEAR);

`ifdef REGFILE_SB_BYPASS_EN
   // Forward writeback to a matching read port while IDLE and out of reset.
   always_comb begin
      byp_x = reset && we && (state == S_IDLE) && (rZ_address != '0) && (rX_address == rZ_address);
      byp_y = reset && we && (state == S_IDLE) && (rZ_address != '0) && (rY_address == rZ_address);
   end
`else
   // No forwarding: reads always return stored contents.
   always_comb begin
      byp_x = 1'b0;
      byp_y = 1'b0;
   end
`endif

   // Combinational read ports; address 0 is forced to zero / not pending.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      rX         = '0;
      rX_pending = 1'b0;
      rY         = '0;
      rY_pending = 1'b0;
      if (rX_address != '0) begin
         rX         = byp_x ? rZ : regs[rX_address];
         rX_pending = pending[rX_address] && !byp_x;
      end
      if (rY_address != '0) begin
         rY         = byp_y ? rZ : regs[rY_address];
         rY_pending = pending[rY_address] && !byp_y;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven vectors with a scoreboard queue, plus
// hand-written clear-sweep and reset-mid-clear sequences.
// Honours REGFILE_SB_BYPASS_EN for the same-cycle bypass expectation.
module tb_regfile_sb;

   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] rX_address, rY_address, rZ_address, issue_address;
   logic [DW-1:0] rX, rY, rZ;
   logic          rX_pending, rY_pending, we, issue_valid, clear_req;
   logic          clear_busy, clear_done;

   regfile_sb #(.dtype(DW), .nregs(NR)) dut (
      .clock(clock), .reset(reset),
      .rX_address(rX_address), .rX(rX), .rX_pending(rX_pending),
      .rY_address(rY_address), .rY(rY), .rY_pending(rY_pending),
      .we(we), .rZ_address(rZ_address), .rZ(rZ),
      .issue_valid(issue_valid), .issue_address(issue_address),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          we;
      logic [AW-1:0] za;
      logic [DW-1:0] zd;
      logic          iv;
      logic [AW-1:0] ia;
      logic [AW-1:0] xa;
      logic [DW-1:0] ex;
      logic          exp_xp;
      logic [AW-1:0] ya;
      logic [DW-1:0] ey;
      logic          eyp;
   } vec_t;

   typedef struct {
      logic [DW-1:0] x;
      logic          xp;
      logic [DW-1:0] y;
      logic          yp;
   } exp_t;

   vec_t vecs[17];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [AW-1:0] za, input logic [DW-1:0] zd,
                               input logic iv, input logic [AW-1:0] ia,
                               input logic [AW-1:0] xa, input logic [DW-1:0] ex, input logic exp_xp,
                               input logic [AW-1:0] ya, input logic [DW-1:0] ey, input logic eyp);
      vec_t v;
      v.we = w; v.za = za; v.zd = zd; v.iv = iv; v.ia = ia;
      v.xa = xa; v.ex = ex; v.exp_xp = exp_xp; v.ya = ya; v.ey = ey; v.eyp = eyp;
      return v;
   endfunction

   task automatic idle_inputs();
      we = 1'b0; rZ_address = '0; rZ = '0;
      issue_valid = 1'b0; issue_address = '0; clear_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   busy_cnt, done_cnt, done_at;
      exp_t e;

      //                 we za zd         iv ia  xa ex         xp  ya ey         yp
      vecs[0]  = mk(1, 0, 16'hBEEF, 0, 0,  0, 16'h0000, 0,  3, 16'h0000, 0);
      vecs[1]  = mk(1, 3, 16'h1234, 0, 0,  0, 16'h0000, 0,  1, 16'h0000, 0);
      vecs[2]  = mk(0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0,  3, 16'h1234, 0);
      vecs[3]  = mk(0, 0, 16'h0000, 1, 5,  5, 16'h0000, 0,  3, 16'h1234, 0);
      vecs[4]  = mk(0, 0, 16'h0000, 0, 0,  5, 16'h0000, 1,  0, 16'h0000, 0);
      vecs[5]  = mk(1, 5, 16'h00AA, 0, 0,  3, 16'h1234, 0,  0, 16'h0000, 0);
      vecs[6]  = mk(0, 0, 16'h0000, 0, 0,  5, 16'h00AA, 0,  0, 16'h0000, 0);
      vecs[7]  = mk(1, 2, 16'h0F0F, 1, 2,  3, 16'h1234, 0,  5, 16'h00AA, 0);
      vecs[8]  = mk(0, 0, 16'h0000, 0, 0,  5, 16'h00AA, 0,  2, 16'h0F0F, 1);
      vecs[9]  = mk(0, 0, 16'h0000, 1, 6,  1, 16'h0000, 0,  6, 16'h0000, 0);
`ifdef REGFILE_SB_BYPASS_EN
      vecs[10] = mk(1, 6, 16'h5A5A, 0, 0,  6, 16'h5A5A, 0,  2, 16'h0F0F, 1);
`else
      vecs[10] = mk(1, 6, 16'h5A5A, 0, 0,  6, 16'h0000, 1,  2, 16'h0F0F, 1);
`endif
      vecs[11] = mk(0, 0, 16'h0000, 0, 0,  6, 16'h5A5A, 0,  0, 16'h0000, 0);
      vecs[12] = mk(1, 1, 16'h1111, 0, 0,  0, 16'h0000, 0,  0, 16'h0000, 0);
      vecs[13] = mk(1, 4, 16'h4444, 0, 0,  0, 16'h0000, 0,  0, 16'h0000, 0);
      vecs[14] = mk(1, 7, 16'h7777, 0, 0,  0, 16'h0000, 0,  0, 16'h0000, 0);
      vecs[15] = mk(0, 0, 16'h0000, 1, 3,  0, 16'h0000, 0,  0, 16'h0000, 0);
      vecs[16] = mk(0, 0, 16'h0000, 0, 0,  3, 16'h1234, 1,  7, 16'h7777, 0);

      // Reset held from time 0, including a write attempt across an edge.
      idle_inputs();
      rX_address = 3; rY_address = 3;
      we = 1'b1; rZ_address = 3; rZ = 16'hBEEF;
      #2;
      check("rst_busy", 32'(clear_busy), 32'd0);
      check("rst_done", 32'(clear_done), 32'd0);
      @(negedge clock);
      #2;
      check("rst_rx", 32'(rX), 32'd0);
      check("rst_rxp", 32'(rX_pending), 32'd0);
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;

      // Table-driven vectors through the scoreboard queue.
      for (int i = 0; i < 17; i++) begin
         @(negedge clock);
         we = vecs[i].we; rZ_address = vecs[i].za; rZ = vecs[i].zd;
         issue_valid = vecs[i].iv; issue_address = vecs[i].ia;
         rX_address = vecs[i].xa; rY_address = vecs[i].ya;
         sb.push_back('{vecs[i].ex, vecs[i].exp_xp, vecs[i].ey, vecs[i].eyp});
         #2;
         e = sb.pop_front();
         check($sformatf("v%0d_rx", i), 32'(rX), 32'(e.x));
         check($sformatf("v%0d_rxp", i), 32'(rX_pending), 32'(e.xp));
         check($sformatf("v%0d_ry", i), 32'(rY), 32'(e.y));
         check($sformatf("v%0d_ryp", i), 32'(rY_pending), 32'(e.yp));
      end

      // Clear sweep: clear_req with a same-cycle write, then writes during sweep.
      @(negedge clock);
      idle_inputs();
      clear_req = 1'b1; we = 1'b1; rZ_address = 1; rZ = 16'h0101;
      #2;
      check("clr_busy_pre", 32'(clear_busy), 32'd0);
      @(negedge clock);
      clear_req = 1'b0; we = 1'b1; rZ_address = 4; rZ = 16'hBBBB;
      issue_valid = 1'b1; issue_address = 4;
      rX_address = 1; rY_address = 7;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clock);
         if (c == 4) begin rX_address = 3; rY_address = 5; end
         if (c == 8) begin we = 1'b0; issue_valid = 1'b0; end
         #2;
         if (c == 1) begin
            check("clr_c1_rx", 32'(rX), 32'h0101);
            check("clr_c1_ry", 32'(rY), 32'h7777);
         end
         if (c == 4) begin
            check("clr_c4_rx_swept", 32'(rX), 32'd0);
            check("clr_c4_ry_unswept", 32'(rY), 32'h00AA);
         end
         if (clear_busy) busy_cnt++;
         if (clear_done) begin done_cnt++; done_at = c; end
      end
      check("clr_busy_cycles", 32'(busy_cnt), 32'd7);
      check("clr_done_pulses", 32'(done_cnt), 32'd1);
      check("clr_done_cycle", 32'(done_at), 32'd8);
      for (int a = 0; a < NR; a++) begin
         @(negedge clock);
         rX_address = AW'(a); rY_address = AW'(a);
         #2;
         check($sformatf("clr_r%0d", a), 32'(rX), 32'd0);
         check($sformatf("clr_p%0d", a), 32'(rY_pending), 32'd0);
      end

      // Reset asserted on the third CLEAR cycle.
      @(negedge clock);
      we = 1'b1; rZ_address = 3; rZ = 16'h3333;
      @(negedge clock);
      rZ_address = 7; rZ = 16'h7777; issue_valid = 1'b1; issue_address = 2;
      @(negedge clock);
      idle_inputs();
      clear_req = 1'b1;
      rX_address = 7; rY_address = 2;
      for (int c = 1; c <= 3; c++) @(negedge clock);
      clear_req = 1'b0;
      #1;
      check("rmc_busy_before", 32'(clear_busy), 32'd1);
      check("rmc_rx_before", 32'(rX), 32'h7777);
      reset = 1'b0;
      #1;
      check("rmc_busy_now", 32'(clear_busy), 32'd0);
      check("rmc_rx_zero", 32'(rX), 32'd0);
      check("rmc_ryp_zero", 32'(rY_pending), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      done_cnt = 0; busy_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         #2;
         if (clear_done) done_cnt++;
         if (clear_busy) busy_cnt++;
      end
      check("rmc_no_done", 32'(done_cnt), 32'd0);
      check("rmc_no_busy", 32'(busy_cnt), 32'd0);
      rX_address = 3;
      #1;
      check("rmc_r3_zero", 32'(rX), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
